// File: rtl/adc_frame_rx.sv
// ADC serial frame receiver: one conversion per chip-select frame, valid/ready output.
// Optional averaging of good frames when ADC_RX_AVG_EN is defined.
module adc_frame_rx #(
    parameter int unsigned ADC_WIDTH = 12,
    parameter int unsigned AVG_LOG2  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 shift_en,
    input  logic                 sdi,
    output logic [ADC_WIDTH-1:0] sample_data,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 ovr_clr,
    output logic [15:0]          frame_cnt
);

    localparam int unsigned CNT_W = $clog2(ADC_WIDTH + 2);
    localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(ADC_WIDTH);
    localparam logic [CNT_W-1:0] BITS_SAT  = CNT_W'(ADC_WIDTH + 1);

    if (AVG_LOG2 > 8) begin : g_avg_range
        $error("adc_frame_rx: AVG_LOG2 must not exceed 8");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    logic [ADC_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 close_c;
    logic                 good_c;
    logic                 load_c;
    logic [ADC_WIDTH-1:0] load_data_c;

    // Frame closes on the cs rising edge seen while in SHIFT.
    assign close_c = (state == SHIFT) && cs;
    assign good_c  = close_c && (bit_cnt == BITS_FULL);

`ifdef ADC_RX_AVG_EN
    localparam int unsigned SUM_W = ADC_WIDTH + AVG_LOG2;
    localparam int unsigned AVG_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [AVG_W-1:0] AVG_LAST = AVG_W'((1 << AVG_LOG2) - 1);

    logic [SUM_W-1:0] sum;
    logic [AVG_W-1:0] avg_cnt;
    logic [SUM_W-1:0] total_c;

    assign total_c     = sum + SUM_W'(shreg);
    assign load_c      = good_c && (avg_cnt == AVG_LAST);
    assign load_data_c = ADC_WIDTH'(total_c >> AVG_LOG2);

    // Accumulate good frames; the window's last frame is folded into the emitted average.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= '0;
            avg_cnt <= '0;
        end else if (good_c) begin
            if (load_c) begin
                sum     <= '0;
                avg_cnt <= '0;
            end else begin
                sum     <= total_c;
                avg_cnt <= avg_cnt + AVG_W'(1);
            end
        end
    end
`else
    assign load_c      = good_c;
    assign load_data_c = shreg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            frame_err <= close_c && (bit_cnt != BITS_FULL);

            case (state)
                IDLE: begin
                    if (!cs) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (cs) begin
                        state <= IDLE;
                    end else if (shift_en) begin
                        shreg <= {shreg[ADC_WIDTH-2:0], sdi};
                        if (bit_cnt != BITS_SAT) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (good_c) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            // A load in the same cycle as a handshake keeps valid high with the new data.
            if (load_c) begin
                sample_data  <= load_data_c;
                sample_valid <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (load_c && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
